// File: rtl/sfq_splitter_scheduler_pkg.sv
// Shared types, defaults and the round-robin pick helper for the SFQ splitter scheduler.
package sfq_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } sched_state_t;

   localparam int DEFAULT_N_REQ   = 4;
   localparam int DEFAULT_TIMEOUT = 8;
   localparam int DEFAULT_HOLDOFF = 3;
   localparam int DEFAULT_CNT_W   = 16;

   // Returns the first set request strictly after ptr, wrapping modulo n.
   // Requests are passed zero-extended to 8 bits, the largest supported count.
   function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                          input logic [2:0] ptr,
                                          input logic [3:0] n);
      logic       found;
      logic [3:0] sum;
      logic [2:0] pick;
      found = 1'b0;
      pick  = 3'd0;
      for (logic [3:0] off = 4'd1; off <= 4'd8; off++) begin
         sum = {1'b0, ptr} + off;
         if (sum >= n) sum = sum - n;
         if ((off <= n) && !found && req[sum[2:0]]) begin
            found = 1'b1;
            pick  = sum[2:0];
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/sfq_splitter_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request after rr_ptr.
module sfq_rr_arbiter
   import sfq_sched_pkg::*;
#(
   parameter  int N_REQ = DEFAULT_N_REQ,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] onehot,
   output logic [IDX_W-1:0] index
);

   logic [7:0] req_wide;
   logic [2:0] ptr_wide;
   logic [2:0] pick;
   logic       pick_unused;

   // Widen the request vector and pointer to the helper's fixed 8-way form.
   always_comb begin
      req_wide              = '0;
      req_wide[N_REQ-1:0]   = req;
      ptr_wide              = '0;
      ptr_wide[IDX_W-1:0]   = rr_ptr;
      pick                  = rr_pick(req_wide, ptr_wide, 4'(N_REQ));
   end

   assign index       = pick[IDX_W-1:0];
   assign pick_unused = ^pick;

   // One-hot form of the winner, empty when nobody is requesting.
   always_comb begin
      onehot = '0;
      if (|req) onehot[index] = 1'b1;
   end

endmodule

// File: rtl/sfq_splitter_scheduler.sv
// Shares one splitter cell between N_REQ requesters: fires one toggle-encoded
// pulse per grant, waits for both fan-out toggles (or a timeout), then holds off.
module sfq_splitter_scheduler
   import sfq_sched_pkg::*;
#(
   parameter  int N_REQ   = DEFAULT_N_REQ,
   parameter  int TIMEOUT = DEFAULT_TIMEOUT,
   parameter  int HOLDOFF = DEFAULT_HOLDOFF,
   parameter  int CNT_W   = DEFAULT_CNT_W,
   localparam int IDX_W   = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             spl_in,
   input  logic             spl_out1,
   input  logic             spl_out2,
   output logic             busy,
   output logic             err,
   output logic [IDX_W-1:0] err_req,
   output logic [CNT_W-1:0] fire_cnt
);

   localparam int WCNT_W = $clog2(TIMEOUT + 1);
   localparam int HCNT_W = $clog2(HOLDOFF + 1);

   sched_state_t      state;
   logic              out1_q;
   logic              out2_q;
   logic              seen1;
   logic              seen2;
   logic [WCNT_W-1:0] wcnt;
   logic [HCNT_W-1:0] hcnt;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  cur_req;

   logic              t1;
   logic              t2;
   logic              seen1_next;
   logic              seen2_next;
   logic [WCNT_W-1:0] wcnt_next;
   logic              wait_done;
   logic              wait_timeout;
   logic              violation;
   logic [N_REQ-1:0]  arb_onehot;
   logic [IDX_W-1:0]  arb_index;

   sfq_rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arbiter (
      .req    (req),
      .rr_ptr (rr_ptr),
      .onehot (arb_onehot),
      .index  (arb_index)
   );

   assign t1   = spl_out1 ^ out1_q;
   assign t2   = spl_out2 ^ out2_q;
   assign busy = (state != IDLE);

   // Next-cycle bookkeeping for WAIT and the violation condition for the current state.
   always_comb begin
      seen1_next   = seen1 | t1;
      seen2_next   = seen2 | t2;
      wcnt_next    = wcnt + WCNT_W'(1);
      wait_done    = seen1_next && seen2_next;
      wait_timeout = (wcnt_next == WCNT_W'(TIMEOUT));
      violation    = 1'b0;
      case (state)
         WAIT:    violation = (t1 && seen1) || (t2 && seen2) || (wait_timeout && !wait_done);
         default: violation = t1 || t2;
      endcase
   end

   // Scheduler FSM with its counters, round-robin pointer and sticky error capture.
   always_ff @(posedge clk) begin
      out1_q <= spl_out1;
      out2_q <= spl_out2;
      if (rst) begin
         state    <= IDLE;
         spl_in   <= 1'b0;
         gnt      <= '0;
         err      <= 1'b0;
         err_req  <= '0;
         fire_cnt <= '0;
         rr_ptr   <= IDX_W'(N_REQ - 1);
         cur_req  <= '0;
         seen1    <= 1'b0;
         seen2    <= 1'b0;
         wcnt     <= '0;
         hcnt     <= '0;
      end else begin
         gnt <= '0;
         if (violation && !err) begin
            err     <= 1'b1;
            err_req <= cur_req;
         end
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt      <= arb_onehot;
                  spl_in   <= ~spl_in;
                  fire_cnt <= fire_cnt + CNT_W'(1);
                  rr_ptr   <= arb_index;
                  cur_req  <= arb_index;
                  seen1    <= 1'b0;
                  seen2    <= 1'b0;
                  wcnt     <= '0;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               seen1 <= seen1_next;
               seen2 <= seen2_next;
               wcnt  <= wcnt_next;
               if (wait_done || wait_timeout) begin
                  hcnt  <= HCNT_W'(HOLDOFF);
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (hcnt == HCNT_W'(1)) state <= IDLE;
               else                    hcnt  <= hcnt - HCNT_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sfq_splitter_scheduler.sv
// Self-checking bench for sfq_splitter_scheduler: directed protocol and error
// scenarios followed by randomized requests against a transaction-level model.
module tb_sfq_splitter_scheduler;

   localparam int N_REQ   = 4;
   localparam int TIMEOUT = 8;
   localparam int HOLDOFF = 3;
   localparam int CNT_W   = 16;

   logic             clk;
   logic             rst;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic             spl_in;
   logic             spl_out1;
   logic             spl_out2;
   logic             busy;
   logic             err;
   logic [1:0]       err_req;
   logic [CNT_W-1:0] fire_cnt;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Behavioural splitter: delays (in cycles) from an observed spl_in toggle to each
   // output toggle; 0 means that output never answers. x1 adds a second out1 toggle.
   logic last_in     = 1'b0;
   int   d1          = 2;
   int   d2          = 2;
   int   x1          = 0;
   int   cd1         = 0;
   int   cd2         = 0;
   int   cx1         = 0;
   bit   rand_delays = 1'b0;

   sfq_splitter_scheduler #(
      .N_REQ   (N_REQ),
      .TIMEOUT (TIMEOUT),
      .HOLDOFF (HOLDOFF),
      .CNT_W   (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .gnt      (gnt),
      .spl_in   (spl_in),
      .spl_out1 (spl_out1),
      .spl_out2 (spl_out2),
      .busy     (busy),
      .err      (err),
      .err_req  (err_req),
      .fire_cnt (fire_cnt)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock edge, then sample point; the splitter model reacts here.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (spl_in !== last_in) begin
         last_in = spl_in;
         if (rst) begin
            cd1 = 0;
            cd2 = 0;
            cx1 = 0;
         end else begin
            if (rand_delays) begin
               d1 = int'($urandom_range(1, TIMEOUT));
               d2 = int'($urandom_range(1, TIMEOUT));
            end
            cd1 = d1;
            cd2 = d2;
         end
      end
      if (cd1 > 0) begin
         cd1--;
         if (cd1 == 0) begin
            spl_out1 = ~spl_out1;
            if (x1 > 0) cx1 = x1;
         end
      end else if (cx1 > 0) begin
         cx1--;
         if (cx1 == 0) spl_out1 = ~spl_out1;
      end
      if (cd2 > 0) begin
         cd2--;
         if (cd2 == 0) spl_out2 = ~spl_out2;
      end
   endtask

   task automatic applyStimulus(input logic [N_REQ-1:0] r);
      req = r;
      tick();
   endtask

   task automatic resetDut();
      rst = 1'b1;
      req = '0;
      cd1 = 0;
      cd2 = 0;
      cx1 = 0;
      x1  = 0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Reference round-robin rule: first pending requester after the last one served.
   function automatic int model_pick(input logic [N_REQ-1:0] r, input int last);
      int cand;
      for (int step = 1; step <= N_REQ; step++) begin
         cand = (last + step) % N_REQ;
         if (r[cand[1:0]]) return cand;
      end
      return -1;
   endfunction

   int               busy_cycles;
   int               extra_gnt;
   int               n_g;
   int               prev_g;
   int               err_seen;
   int               c0;
   bit               got;
   logic [N_REQ-1:0] exp_gnt;
   logic [N_REQ-1:0] pend;
   int               ptr;
   int               ready;
   int               fire_at;
   int               k_last;
   int               fires;
   int               idx;
   logic             parity;
   bit               expect_fire;

   initial begin
      rst      = 1'b1;
      req      = '0;
      spl_out1 = 1'b0;
      spl_out2 = 1'b0;

      // Single pulse with a 2-cycle splitter response.
      $display("[TB] single pulse");
      d1 = 2; d2 = 2;
      resetDut();
      checkOutput("rst_gnt", 32'(gnt), 32'(0));
      checkOutput("rst_spl_in", 32'(spl_in), 32'(0));
      checkOutput("rst_busy", 32'(busy), 32'(0));
      checkOutput("rst_err", 32'(err), 32'(0));
      checkOutput("rst_err_req", 32'(err_req), 32'(0));
      checkOutput("rst_fire_cnt", 32'(fire_cnt), 32'(0));
      applyStimulus(4'b0001);
      checkOutput("t1_gnt", 32'(gnt), 32'(4'b0001));
      checkOutput("t1_spl_in", 32'(spl_in), 32'(1));
      checkOutput("t1_fire_cnt", 32'(fire_cnt), 32'(1));
      busy_cycles = busy ? 1 : 0;
      extra_gnt   = 0;
      req = '0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (busy) busy_cycles++;
         if (gnt !== '0) extra_gnt++;
      end
      checkOutput("t1_busy_cycles", 32'(busy_cycles), 32'(2 + HOLDOFF));
      checkOutput("t1_extra_gnt", 32'(extra_gnt), 32'(0));
      checkOutput("t1_err", 32'(err), 32'(0));

      // All four requesters held: strict rotation, fixed spacing.
      $display("[TB] round robin");
      resetDut();
      req    = 4'b1111;
      n_g    = 0;
      prev_g = 0;
      for (int i = 0; i < 40 && n_g < 5; i++) begin
         tick();
         if (gnt !== '0) begin
            exp_gnt = '0;
            exp_gnt[n_g % N_REQ] = 1'b1;
            checkOutput("t2_gnt_order", 32'(gnt), 32'(exp_gnt));
            if (n_g > 0) checkOutput("t2_spacing", 32'(cyc - prev_g), 32'(2 + HOLDOFF + 1));
            prev_g = cyc;
            n_g++;
         end
      end
      req = '0;
      checkOutput("t2_grant_count", 32'(n_g), 32'(5));
      checkOutput("t2_fire_cnt", 32'(fire_cnt), 32'(5));
      for (int i = 0; i < 8; i++) tick();
      checkOutput("t2_err", 32'(err), 32'(0));

      // Output 2 never answers: timeout error, then the next request is served.
      $display("[TB] timeout");
      resetDut();
      d1 = 2; d2 = 0;
      applyStimulus(4'b0001);
      checkOutput("t3_gnt", 32'(gnt), 32'(4'b0001));
      req = 4'b0100;
      d2  = 2;
      err_seen = 0;
      for (int i = 1; i < TIMEOUT; i++) begin
         tick();
         if (err) err_seen++;
      end
      checkOutput("t3_err_early", 32'(err_seen), 32'(0));
      tick();
      checkOutput("t3_err", 32'(err), 32'(1));
      checkOutput("t3_err_req", 32'(err_req), 32'(0));
      checkOutput("t3_busy_hold", 32'(busy), 32'(1));
      for (int i = 1; i < HOLDOFF; i++) tick();
      checkOutput("t3_busy_last_hold", 32'(busy), 32'(1));
      tick();
      checkOutput("t3_idle", 32'(busy), 32'(0));
      tick();
      checkOutput("t3_next_gnt", 32'(gnt), 32'(4'b0100));
      checkOutput("t3_err_sticky", 32'(err), 32'(1));
      req = '0;
      for (int i = 0; i < 8; i++) tick();

      // Double toggle on output 1; a later violation must not overwrite err_req.
      $display("[TB] double toggle");
      resetDut();
      d1 = 1; x1 = 2; d2 = 5;
      applyStimulus(4'b0010);
      c0 = cyc;
      checkOutput("t4_gnt", 32'(gnt), 32'(4'b0010));
      req = 4'b1000;
      x1  = 0; d1 = 2; d2 = 0;
      tick();
      tick();
      checkOutput("t4_err_before", 32'(err), 32'(0));
      tick();
      checkOutput("t4_err", 32'(err), 32'(1));
      checkOutput("t4_err_req", 32'(err_req), 32'(1));
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         tick();
         if (gnt !== '0) got = 1'b1;
      end
      checkOutput("t4_regrant", 32'(gnt), 32'(4'b1000));
      checkOutput("t4_regrant_time", 32'(cyc - c0), 32'(5 + HOLDOFF + 1));
      req = '0;
      for (int i = 0; i < TIMEOUT + 1; i++) tick();
      checkOutput("t4_err_kept", 32'(err), 32'(1));
      checkOutput("t4_err_req_kept", 32'(err_req), 32'(1));
      for (int i = 0; i < HOLDOFF + 2; i++) tick();

      // Toggle landing exactly on the timeout cycle counts as seen.
      $display("[TB] timeout boundary");
      resetDut();
      d1 = TIMEOUT; d2 = 1;
      applyStimulus(4'b0100);
      req = '0;
      for (int i = 0; i < TIMEOUT; i++) tick();
      checkOutput("t5_err_boundary", 32'(err), 32'(0));
      for (int i = 0; i < HOLDOFF - 1; i++) tick();
      checkOutput("t5_busy_hold", 32'(busy), 32'(1));
      tick();
      checkOutput("t5_idle", 32'(busy), 32'(0));

      // Spurious toggle while idle.
      $display("[TB] spurious pulse");
      d1 = 2; d2 = 2;
      resetDut();
      tick();
      tick();
      spl_out1 = ~spl_out1;
      tick();
      checkOutput("t6_err", 32'(err), 32'(1));
      checkOutput("t6_gnt", 32'(gnt), 32'(0));
      checkOutput("t6_fire_cnt", 32'(fire_cnt), 32'(0));
      checkOutput("t6_err_req", 32'(err_req), 32'(0));

      // Reset in the middle of WAIT with a request held.
      $display("[TB] reset during wait");
      resetDut();
      applyStimulus(4'b0010);
      checkOutput("t7_gnt", 32'(gnt), 32'(4'b0010));
      tick();
      rst = 1'b1;
      tick();
      checkOutput("t7_rst_spl_in", 32'(spl_in), 32'(0));
      checkOutput("t7_rst_busy", 32'(busy), 32'(0));
      checkOutput("t7_rst_err", 32'(err), 32'(0));
      checkOutput("t7_rst_fire_cnt", 32'(fire_cnt), 32'(0));
      rst = 1'b0;
      tick();
      checkOutput("t7_regrant", 32'(gnt), 32'(4'b0010));
      checkOutput("t7_spl_in", 32'(spl_in), 32'(1));
      checkOutput("t7_fire_cnt", 32'(fire_cnt), 32'(1));
      req = '0;
      for (int i = 0; i < 10; i++) tick();
      checkOutput("t7_err_after", 32'(err), 32'(0));

      // Randomized requests and splitter delays against the transaction-level model.
      $display("[TB] random traffic");
      resetDut();
      rand_delays = 1'b1;
      pend    = '0;
      ptr     = N_REQ - 1;
      ready   = 0;
      fire_at = -1000;
      k_last  = 0;
      fires   = 0;
      parity  = 1'b0;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < N_REQ; i++)
            if (!pend[i] && $urandom_range(0, 3) == 0) pend[i] = 1'b1;
         expect_fire = (cyc + 1 >= ready) && (pend != '0);
         applyStimulus(pend);
         exp_gnt = '0;
         if (expect_fire) begin
            idx = model_pick(pend, ptr);
            exp_gnt[idx[1:0]] = 1'b1;
            pend[idx[1:0]]    = 1'b0;
            ptr     = idx;
            fires++;
            parity  = ~parity;
            fire_at = cyc;
            k_last  = (d1 > d2) ? d1 : d2;
            ready   = cyc + k_last + HOLDOFF + 1;
         end
         checkOutput("rand_gnt", 32'(gnt), 32'(exp_gnt));
         checkOutput("rand_fire_cnt", 32'(fire_cnt), 32'(fires));
         checkOutput("rand_spl_in", 32'(spl_in), 32'(parity));
         checkOutput("rand_busy", 32'(busy), 32'(cyc < fire_at + k_last + HOLDOFF));
         checkOutput("rand_err", 32'(err), 32'(0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
